// File: rtl/lut_sweep_eval.sv
// ---------------------------------------------------------------------------
// lut_sweep_eval
//
// Programmable boolean function unit with a 2^N_IN-entry truth table.
//   * Direct mode: s is the registered lookup table[x], one cycle of latency.
//   * Sweep mode:  after a start request, the unit streams every (index, f)
//                  pair over a valid/ready handshake. It then pulses done and
//                  reports how many table entries are 1.
//
// Optional feature (compile-time macro TT_PARITY_EN):
//   When defined, two extra outputs are added:
//     tt_parity -- XOR of all table entries.
//     par_err   -- pulses with done when the sweep's minterm count disagrees
//                  with tt_parity.
//   When undefined, neither port exists.
//
// Ports:
//   clk        in   clock
//   reset      in   asynchronous, active-high reset
//   x          in   [N_IN]    direct-mode input vector
//   s          out  1         registered f(x)
//   tt_we      in   1         truth-table write strobe (ignored while sweeping)
//   tt_addr    in   [N_IN]    entry to write
//   tt_din     in   1         value to write
//   start      in   1         sweep request, sampled every cycle
//   busy       out  1         high while in SWEEP
//   out_valid  out  1         sweep stream valid
//   out_ready  in   1         sweep stream ready
//   out_idx    out  [N_IN]    current sweep index
//   out_s      out  1         f(out_idx) for the current beat
//   done       out  1         one-cycle pulse when a sweep completes
//   ones_cnt   out  [N_IN+1]  number of 1 entries found by the last sweep
//   tt_parity  out  1         (TT_PARITY_EN) XOR of all table entries
//   par_err    out  1         (TT_PARITY_EN) parity/count disagreement pulse
// ---------------------------------------------------------------------------
module lut_sweep_eval #(
  parameter int                     N_IN    = 4,
  parameter logic [(1<<N_IN)-1:0]   TT_INIT = 16'hAC3C
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_IN-1:0] x,
  output logic            s,
  input  logic            tt_we,
  input  logic [N_IN-1:0] tt_addr,
  input  logic            tt_din,
  input  logic            start,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N_IN-1:0] out_idx,
  output logic            out_s,
  output logic            done,
`ifdef TT_PARITY_EN
  output logic            tt_parity,
  output logic            par_err,
`endif
  output logic [N_IN:0]   ones_cnt
);

  localparam int              DEPTH    = 1 << N_IN;
  localparam logic [N_IN-1:0] LAST_IDX = {N_IN{1'b1}};

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t             state, state_nxt;
  logic [DEPTH-1:0]   tt, tt_nxt;
  logic [N_IN:0]      count, count_nxt;
  logic               wr_en;
  logic               xfer;
  logic               last_beat;
  logic               enter_sweep;

  // The table is frozen during a sweep, so a combinational lookup of the
  // current index stays stable across stalls. Gating with out_valid keeps
  // out_s at 0 outside the stream.
  assign out_s = out_valid & tt[out_idx];
  assign busy  = (state == SWEEP);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    wr_en       = tt_we && (state != SWEEP);
    xfer        = (state == SWEEP) && out_valid && out_ready;
    last_beat   = xfer && (out_idx == LAST_IDX);
    count_nxt   = count + (N_IN+1)'(out_s);
    tt_nxt      = tt;
    if (wr_en) tt_nxt[tt_addr] = tt_din;

    case (state)
      IDLE:    if (start) state_nxt = SWEEP;
      SWEEP:   if (last_beat) state_nxt = DONE;
      DONE:    state_nxt = start ? SWEEP : IDLE;
      default: state_nxt = IDLE;
    endcase

    enter_sweep = (state != SWEEP) && (state_nxt == SWEEP);
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples pre-edge values, which gives the "old value on a same-cycle
  // write" behaviour of s for free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      // NOTE: the table is a small flop array rather than a RAM, so it can be
      // (and must be) restored to TT_INIT by reset.
      tt        <= TT_INIT;
      s         <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      count     <= '0;
      ones_cnt  <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      tt    <= tt_nxt;
      s     <= tt[x];
      done  <= 1'b0;

      if (enter_sweep) begin
        out_idx   <= '0;
        count     <= '0;
        out_valid <= 1'b1;
      end else if (xfer) begin
        count <= count_nxt;
        if (last_beat) begin
          // Hold out_idx at the last index; it must not wrap before the FSM
          // leaves SWEEP.
          out_valid <= 1'b0;
          ones_cnt  <= count_nxt;
          done      <= 1'b1;
        end else begin
          out_idx <= out_idx + 1'b1;
        end
      end
    end
  end

`ifdef TT_PARITY_EN
  // Parity is recomputed from the post-write table. An accepted write
  // therefore shows up on tt_parity in the cycle after the strobe. The
  // table cannot change during a sweep, so tt_parity is stable when
  // par_err is evaluated on the final beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tt_parity <= 1'b0;
      par_err   <= 1'b0;
    end else begin
      tt_parity <= ^tt_nxt;
      par_err   <= last_beat && (count_nxt[0] != tt_parity);
    end
  end
`endif

endmodule

// File: tb/tb_lut_sweep_eval.sv
// ---------------------------------------------------------------------------
// tb_lut_sweep_eval
//
// Directed testbench for lut_sweep_eval (N_IN=4, default truth table).
// Inputs are driven 1 time unit after each rising edge. Outputs are sampled
// at that same point, so every sampled value reflects the preceding edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lut_sweep_eval;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] x;
  logic       s;
  logic       tt_we;
  logic [3:0] tt_addr;
  logic       tt_din;
  logic       start;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_idx;
  logic       out_s;
  logic       done;
  logic [4:0] ones_cnt;
`ifdef TT_PARITY_EN
  logic       tt_parity;
  logic       par_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Hand-derived from s=(b|c)&(a|~b|~c)&(~a|~b|d), x={a,b,c,d}:
  // minterms 2,3,4,5,10,11,13,15.
  logic [15:0] exp_init;
  logic [15:0] all_ones;
  logic [15:0] init_plus0;

  lut_sweep_eval #(.N_IN(4), .TT_INIT(16'hAC3C)) dut (
    .clk       (clk),
    .reset     (reset),
    .x         (x),
    .s         (s),
    .tt_we     (tt_we),
    .tt_addr   (tt_addr),
    .tt_din    (tt_din),
    .start     (start),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_s     (out_s),
    .done      (done),
`ifdef TT_PARITY_EN
    .tt_parity (tt_parity),
    .par_err   (par_err),
`endif
    .ones_cnt  (ones_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    n_checks++;
    if (s !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || out_idx !== 4'd0 ||
        out_s !== 1'b0 || done !== 1'b0 || ones_cnt !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_state: s=%b busy=%b valid=%b idx=%0d out_s=%b done=%b ones=%0d, required all zero",
               s, busy, out_valid, out_idx, out_s, done, ones_cnt);
    end
`ifdef TT_PARITY_EN
    n_checks++;
    if (tt_parity !== 1'b0 || par_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_parity: tt_parity=%b par_err=%b, required 0 0", tt_parity, par_err);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_direct();
    for (int i = 0; i < 16; i++) begin
      x = 4'(i);
      tick();
      n_checks++;
      if (s !== exp_init[i]) begin
        n_fail++;
        $display("FAIL direct_x%0d: s=%b, required %b", i, s, exp_init[i]);
      end
    end
  endtask

  // Runs one sweep. Each cycle it checks the presented beat against tbl,
  // then advances the expected index only when ready was offered.
  task automatic run_sweep(input string name, input logic [15:0] tbl,
                           input logic [4:0] exp_ones, input bit toggle,
                           input bit wr_mid);
    int  idx = 0;
    int  cyc = 0;
    bit  rdy;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_busy: busy=%b, required 1", name, busy);
    end
    while (idx < 16 && cyc < 100) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_idx !== 4'(idx) || out_s !== tbl[idx] || done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_beat%0d: valid=%b idx=%0d out_s=%b done=%b, required 1 %0d %b 0",
                 name, idx, out_valid, out_idx, out_s, done, idx, tbl[idx]);
      end
      rdy = toggle ? (cyc % 3 == 0) : 1'b1;
      out_ready = rdy;
      if (wr_mid && cyc == 3) begin
        tt_we = 1'b1; tt_addr = 4'd0; tt_din = 1'b0;
      end else begin
        tt_we = 1'b0;
      end
      tick();
      cyc++;
      if (rdy) idx++;
    end
    tt_we = 1'b0;
    out_ready = 1'b1;
    if (idx < 16) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: %0d beats in %0d cycles, required 16", name, idx, cyc);
    end
    n_checks++;
    if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || ones_cnt !== exp_ones) begin
      n_fail++;
      $display("FAIL %s_done: done=%b valid=%b busy=%b ones=%0d, required 1 0 0 %0d",
               name, done, out_valid, busy, ones_cnt, exp_ones);
    end
`ifdef TT_PARITY_EN
    n_checks++;
    if (par_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_par_err: par_err=%b, required 0", name, par_err);
    end
`endif
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || ones_cnt !== exp_ones) begin
      n_fail++;
      $display("FAIL %s_after: done=%b busy=%b ones=%0d, required 0 0 %0d",
               name, done, busy, ones_cnt, exp_ones);
    end
  endtask

  task automatic test_sweep_ready();
    run_sweep("sweep_ready", exp_init, 5'd8, 1'b0, 1'b0);
  endtask

  task automatic test_sweep_stall();
    run_sweep("sweep_stall", exp_init, 5'd8, 1'b1, 1'b0);
  endtask

  task automatic test_all_ones();
    for (int a = 0; a < 16; a++) begin
      x = 4'(a); tt_we = 1'b1; tt_addr = 4'(a); tt_din = 1'b1;
      tick();
      // Same-cycle write to the looked-up entry returns the old value.
      if (a == 6) begin
        n_checks++;
        if (s !== 1'b0) begin
          n_fail++;
          $display("FAIL write_same_cycle: s=%b, required 0", s);
        end
      end
    end
    tt_we = 1'b0;
    x = 4'd6;
    tick();
    n_checks++;
    if (s !== 1'b1) begin
      n_fail++;
      $display("FAIL write_visible: s=%b, required 1", s);
    end
    run_sweep("sweep_all_ones", all_ones, 5'd16, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_sweep();
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    n_checks++;
    if (out_idx !== 4'd7 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_beat7: idx=%0d valid=%b, required 7 1", out_idx, out_valid);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL midrst_async: valid=%b busy=%b done=%b idx=%0d, required 0 0 0 0",
               out_valid, busy, done, out_idx);
    end
    tick();
    reset = 1'b0;
    x = 4'd2;
    tick();
    n_checks++;
    if (s !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_x2: s=%b done=%b busy=%b, required 1 0 0", s, done, busy);
    end
    x = 4'd0;
    tick();
    n_checks++;
    if (s !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_x0: s=%b done=%b, required 0 0", s, done);
    end
  endtask

`ifdef TT_PARITY_EN
  task automatic test_parity();
    n_checks++;
    if (tt_parity !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_init: tt_parity=%b, required 0", tt_parity);
    end
    tt_we = 1'b1; tt_addr = 4'd0; tt_din = 1'b1;
    tick();
    tt_we = 1'b0;
    n_checks++;
    if (tt_parity !== 1'b1) begin
      n_fail++;
      $display("FAIL parity_write: tt_parity=%b, required 1", tt_parity);
    end
    run_sweep("sweep_parity", init_plus0, 5'd9, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    exp_init = '0;
    exp_init[2] = 1'b1;  exp_init[3] = 1'b1;  exp_init[4] = 1'b1;
    exp_init[5] = 1'b1;  exp_init[10] = 1'b1; exp_init[11] = 1'b1;
    exp_init[13] = 1'b1; exp_init[15] = 1'b1;
    all_ones = '1;
    init_plus0 = exp_init;
    init_plus0[0] = 1'b1;

    reset = 1'b1; x = '0; tt_we = 1'b0; tt_addr = '0; tt_din = 1'b0;
    start = 1'b0; out_ready = 1'b1;

    test_reset();
    test_direct();
    test_sweep_ready();
    test_sweep_stall();
    test_all_ones();
    test_reset_mid_sweep();
`ifdef TT_PARITY_EN
    test_parity();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lut_sweep_eval.md
Name: lut_sweep_eval

Overview:
Parametrised successor to the fixed 4-input boolean function blocks. It holds a programmable 2^N_IN-entry truth table and provides two modes. Direct mode gives a registered lookup for any input vector. Sweep mode autonomously walks every input combination, streams (index, output) pairs over a valid/ready handshake, and reports the minterm count. Used as a self-checking function unit and as a bench stimulus source in the combinational exercise set.

Parameters:
N_IN, 4, number of function inputs; table depth is 2^N_IN.
TT_INIT, 16'hAC3C, reset truth table; bit i is f(x=i); default encodes s=(b|c)&(a|~b|~c)&(~a|~b|d) with x={a,b,c,d}.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
x  input  N_IN  direct-mode input vector
s  output  1  registered direct-mode result f(x)
tt_we  input  1  truth-table write strobe
tt_addr  input  N_IN  entry to write
tt_din  input  1  value to write
start  input  1  sweep request (level sampled per cycle)
busy  output  1  high in SWEEP state
out_valid  output  1  sweep stream valid
out_ready  input  1  sweep stream ready
out_idx  output  N_IN  current sweep index
out_s  output  1  f(out_idx)
done  output  1  one-cycle pulse at sweep end
ones_cnt  output  N_IN+1  number of 1 entries found in last sweep

Behaviour:
- Reset (async, active-high): table=TT_INIT, state=IDLE, s=0, busy=0, out_valid=0, out_idx=0, out_s=0, done=0, ones_cnt=0.
- Direct mode: s <= table[x] every clock in every state; latency 1 cycle. A write to the same address in the same cycle: s returns the old value, and the new value is visible the next cycle.
- Writes: tt_we applied at the clock edge only in IDLE/DONE; ignored in SWEEP, so the table stays frozen during a sweep.
- FSM: IDLE -> SWEEP on start=1; SWEEP -> DONE after the beat with index 2^N_IN-1 is accepted; DONE -> IDLE next cycle, or DONE -> SWEEP directly if start=1.
- Entering SWEEP: out_idx=0, internal count cleared, out_valid=1 on the first SWEEP cycle.
- Handshake: a beat transfers when out_valid & out_ready. On transfer, count += out_s and out_idx increments. With out_ready=0, out_idx/out_s/out_valid hold stable. out_valid never drops mid-sweep until the final transfer.
- Final transfer (idx=2^N_IN-1): out_valid=0 next cycle. ones_cnt is loaded with the final count, including the last beat, in the same cycle that done=1. ones_cnt holds until the next sweep completes.
- Width: count is N_IN+1 bits so the all-ones table (2^N_IN) does not wrap. out_idx must not wrap before the FSM exits.
- start while busy: ignored.
- Reset mid-sweep: immediate return to IDLE, stream dropped, no done pulse, table restored to TT_INIT.

Optional Feature:
Macro TT_PARITY_EN.
- Defined: adds output tt_parity (1 bit, reset 0), the XOR of all table entries. It is updated in the cycle after any accepted write. Also adds output par_err, which pulses 1 cycle with done when ones_cnt[0] != tt_parity.
- Undefined: neither port exists; no parity logic.

Test Plan:
- Reset, then sweep x=0..15 in direct mode -> s=1 exactly for x in {2,3,4,5,10,11,13,15} and 0 otherwise, each 1 cycle after x is applied.
- Pulse start with out_ready=1 -> 16 consecutive beats idx 0..15, out_s matching TT_INIT. done pulses in the cycle after beat 15, with ones_cnt=8.
- Sweep with out_ready toggled 1,0,0,1,... -> no index skipped or repeated; idx/out_s stable while stalled; ones_cnt=8.
- Write 1 to all 16 entries, then sweep -> ones_cnt=16 (5'b10000, no wrap). tt_we during the sweep (addr 0, din 0) -> ignored, still 16.
- Assert reset at beat 7 of a sweep -> out_valid=0 and busy=0 immediately, no done, table back to 16'hAC3C (x=2 gives s=1).
- With TT_PARITY_EN: after reset tt_parity=0; write entry 0=1 -> tt_parity=1 next cycle; sweep -> ones_cnt=9, par_err stays 0.
